// File: rtl/mem_stage_ob.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ob
// Purpose  : Memory-access pipeline stage between EXE and WB. Waits for
//            in-order data-SRAM responses and keeps the read data in a hold
//            register, so a stalled WB never loses a response. Aligns and
//            extends load data, feeds the bypass network, and counts requests
//            orphaned by a flush so that their late responses are discarded.
// Ports    : clk/resetn          - clock, synchronous active-low reset
//            exe_*               - instruction handed over from EXE
//            mem_allowin         - stage accepts from EXE this cycle
//            data_sram_data_ok/rdata - in-order response strobe and data
//            flush               - WB exception/ertn flush
//            req_block           - orphan counter full, EXE must not issue
//            wb_*                - registered fields towards WB
//            mem_exc             - valid instruction carries an exception
//            fwd_*               - bypass value / pending-load indication
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ob #(
    parameter int EXC_W     = 16,
    parameter int SIDE_W    = 80,
    parameter int MAX_OUTST = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              exe_valid,
    output logic              mem_allowin,
    input  logic [31:0]       exe_pc,
    input  logic [31:0]       exe_result,
    input  logic [2:0]        exe_ld_op,
    input  logic              exe_st,
    input  logic              exe_req_sent,
    input  logic              exe_gr_we,
    input  logic [4:0]        exe_dest,
    input  logic [EXC_W-1:0]  exe_exc,
    input  logic [SIDE_W-1:0] exe_side,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    input  logic              flush,
    output logic              req_block,
    output logic              wb_valid,
    input  logic              wb_allowin,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_result,
    output logic [4:0]        wb_dest,
    output logic              wb_gr_we,
    output logic [EXC_W-1:0]  wb_exc,
    output logic [SIDE_W-1:0] wb_side,
    output logic              mem_exc,
    output logic              fwd_valid,
    output logic [4:0]        fwd_dest,
    output logic [31:0]       fwd_data,
    output logic              fwd_pending
);

    localparam int                 c_CNT_W     = $clog2(MAX_OUTST + 1);
    localparam logic [c_CNT_W-1:0] c_BLOCK_LVL = c_CNT_W'(MAX_OUTST - 1);

    localparam logic [2:0] c_LD_NONE = 3'd0;
    localparam logic [2:0] c_LD_B    = 3'd1;
    localparam logic [2:0] c_LD_H    = 3'd2;
    localparam logic [2:0] c_LD_W    = 3'd3;
    localparam logic [2:0] c_LD_BU   = 3'd4;
    localparam logic [2:0] c_LD_HU   = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               mem_valid_q, mem_valid_d;
    logic [31:0]        pc_q,        pc_d;
    logic [31:0]        result_q,    result_d;
    logic [2:0]         ld_op_q,     ld_op_d;
    logic               req_sent_q,  req_sent_d;
    logic               gr_we_q,     gr_we_d;
    logic [4:0]         dest_q,      dest_d;
    logic [EXC_W-1:0]   exc_q,       exc_d;
    logic [SIDE_W-1:0]  side_q,      side_d;
    logic               got_data_q,  got_data_d;
    logic [31:0]        data_buf_q,  data_buf_d;
    logic [c_CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic        has_exc;
    logic        ready_go;
    logic        stage_load;
    logic        waiting;
    logic        drop_idle;
    logic        capture;
    logic        drop_dec;
    logic        inc_stage;
    logic        inc_exe;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    // A store's result is its address, same as any non-load, so the store
    // flag carries no information this stage needs.
    logic unused_ok;
    assign unused_ok = exe_st;

    always_comb begin
        has_exc    = |exc_q;
        ready_go   = ~req_sent_q | got_data_q | has_exc;
        mem_allowin = ~mem_valid_q | (ready_go & wb_allowin);
        stage_load = exe_valid & mem_allowin;
        waiting    = mem_valid_q & req_sent_q & ~got_data_q;
        drop_idle  = (drop_cnt_q == '0);

        // Responses are in order: while orphans are outstanding, the next
        // response always belongs to an orphan.
        capture    = data_sram_data_ok & drop_idle & waiting;
        drop_dec   = data_sram_data_ok & ~drop_idle;

        // A waiting request whose response lands on the flush edge has been
        // consumed, so it does not become an orphan.
        inc_stage  = flush & waiting & ~capture;
        inc_exe    = flush & exe_valid & exe_req_sent & mem_allowin;

        drop_cnt_d = drop_cnt_q + c_CNT_W'(inc_stage) + c_CNT_W'(inc_exe)
                     - c_CNT_W'(drop_dec);

        got_data_d = got_data_q;
        if (capture) begin
            got_data_d = 1'b1;
        end
        if (stage_load) begin
            got_data_d = 1'b0;
        end
        data_buf_d = capture ? data_sram_rdata : data_buf_q;

        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (mem_allowin) begin
            mem_valid_d = exe_valid;
        end else begin
            mem_valid_d = mem_valid_q;
        end

        pc_d       = stage_load ? exe_pc       : pc_q;
        result_d   = stage_load ? exe_result   : result_q;
        ld_op_d    = stage_load ? exe_ld_op    : ld_op_q;
        req_sent_d = stage_load ? exe_req_sent : req_sent_q;
        gr_we_d    = stage_load ? exe_gr_we    : gr_we_q;
        dest_d     = stage_load ? exe_dest     : dest_q;
        exc_d      = stage_load ? exe_exc      : exc_q;
        side_d     = stage_load ? exe_side     : side_q;

        // Lane selection by the low address bits.
        case (result_q[1:0])
            2'd0:    ld_byte = data_buf_q[7:0];
            2'd1:    ld_byte = data_buf_q[15:8];
            2'd2:    ld_byte = data_buf_q[23:16];
            default: ld_byte = data_buf_q[31:24];
        endcase
        ld_half = result_q[1] ? data_buf_q[31:16] : data_buf_q[15:0];

        case (ld_op_q)
            c_LD_B:  load_data = {{24{ld_byte[7]}}, ld_byte};
            c_LD_H:  load_data = {{16{ld_half[15]}}, ld_half};
            c_LD_BU: load_data = {24'd0, ld_byte};
            c_LD_HU: load_data = {16'd0, ld_half};
            c_LD_W:  load_data = data_buf_q;
            default: load_data = data_buf_q;
        endcase

        // With an exception the address goes forward for badv.
        if (has_exc || (ld_op_q == c_LD_NONE)) begin
            final_result = result_q;
        end else begin
            final_result = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
            pc_q        <= '0;
            result_q    <= '0;
            ld_op_q     <= '0;
            req_sent_q  <= 1'b0;
            gr_we_q     <= 1'b0;
            dest_q      <= '0;
            exc_q       <= '0;
            side_q      <= '0;
            got_data_q  <= 1'b0;
            data_buf_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            pc_q        <= pc_d;
            result_q    <= result_d;
            ld_op_q     <= ld_op_d;
            req_sent_q  <= req_sent_d;
            gr_we_q     <= gr_we_d;
            dest_q      <= dest_d;
            exc_q       <= exc_d;
            side_q      <= side_d;
            got_data_q  <= got_data_d;
            data_buf_q  <= data_buf_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_block   = (drop_cnt_q >= c_BLOCK_LVL);
    assign wb_valid    = mem_valid_q & ready_go & ~flush;
    assign wb_pc       = pc_q;
    assign wb_result   = final_result;
    assign wb_dest     = dest_q;
    assign wb_gr_we    = gr_we_q;
    assign wb_exc      = exc_q;
    assign wb_side     = side_q;
    assign mem_exc     = mem_valid_q & has_exc;
    assign fwd_valid   = mem_valid_q & gr_we_q;
    assign fwd_dest    = dest_q;
    assign fwd_data    = final_result;
    assign fwd_pending = mem_valid_q & (ld_op_q != c_LD_NONE) & ~got_data_q & ~has_exc;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ob.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_ob
// Purpose  : Self-checking bench for mem_stage_ob. A transaction-level model
//            (stage slot plus a queue of outstanding requests tagged live or
//            orphan) predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ob;

    localparam int EXC_W     = 16;
    localparam int SIDE_W    = 80;
    localparam int MAX_OUTST = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              exe_valid;
    logic              mem_allowin;
    logic [31:0]       exe_pc;
    logic [31:0]       exe_result;
    logic [2:0]        exe_ld_op;
    logic              exe_st;
    logic              exe_req_sent;
    logic              exe_gr_we;
    logic [4:0]        exe_dest;
    logic [EXC_W-1:0]  exe_exc;
    logic [SIDE_W-1:0] exe_side;
    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;
    logic              flush;
    logic              req_block;
    logic              wb_valid;
    logic              wb_allowin;
    logic [31:0]       wb_pc;
    logic [31:0]       wb_result;
    logic [4:0]        wb_dest;
    logic              wb_gr_we;
    logic [EXC_W-1:0]  wb_exc;
    logic [SIDE_W-1:0] wb_side;
    logic              mem_exc;
    logic              fwd_valid;
    logic [4:0]        fwd_dest;
    logic [31:0]       fwd_data;
    logic              fwd_pending;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage_ob #(
        .EXC_W(EXC_W), .SIDE_W(SIDE_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .resetn(resetn),
        .exe_valid(exe_valid), .mem_allowin(mem_allowin),
        .exe_pc(exe_pc), .exe_result(exe_result), .exe_ld_op(exe_ld_op),
        .exe_st(exe_st), .exe_req_sent(exe_req_sent),
        .exe_gr_we(exe_gr_we), .exe_dest(exe_dest),
        .exe_exc(exe_exc), .exe_side(exe_side),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .flush(flush), .req_block(req_block),
        .wb_valid(wb_valid), .wb_allowin(wb_allowin),
        .wb_pc(wb_pc), .wb_result(wb_result), .wb_dest(wb_dest),
        .wb_gr_we(wb_gr_we), .wb_exc(wb_exc), .wb_side(wb_side),
        .mem_exc(mem_exc), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
        .fwd_data(fwd_data), .fwd_pending(fwd_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit                m_valid, m_have, m_req;
    logic [31:0]       m_pc, m_res, m_data;
    logic [2:0]        m_op;
    logic              m_we;
    logic [4:0]        m_dest;
    logic [EXC_W-1:0]  m_exc;
    logic [SIDE_W-1:0] m_side;
    bit                q_orphan[$];   // outstanding requests, oldest first

    initial begin
        m_valid = 0; m_have = 0; m_req = 0;
        m_pc = 0; m_res = 0; m_data = 0; m_op = 0; m_we = 0;
        m_dest = 0; m_exc = 0; m_side = 0;
    end

    function automatic int orphans();
        int c = 0;
        foreach (q_orphan[i]) if (q_orphan[i]) c++;
        return c;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * off)) & 32'hFF;
        h = (d >> (16 * off[1])) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd2:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic bit m_ready();
        return !m_req || m_have || (m_exc != 0);
    endfunction

    function automatic bit m_allow();
        return !m_valid || (m_ready() && wb_allowin);
    endfunction

    function automatic logic [31:0] m_final();
        if (m_exc != 0 || m_op == 3'd0) return m_res;
        return load_val(m_op, m_res[1:0], m_data);
    endfunction

    task automatic model_step();
        bit allow;
        bit orph;
        if (!resetn) begin
            m_valid = 0; m_have = 0; m_req = 0;
            m_pc = 0; m_res = 0; m_data = 0; m_op = 0; m_we = 0;
            m_dest = 0; m_exc = 0; m_side = 0;
            q_orphan.delete();
        end else begin
            allow = m_allow();
            if (data_sram_data_ok && q_orphan.size() > 0) begin
                orph = q_orphan.pop_front();
                if (!orph) begin
                    m_have = 1;
                    m_data = data_sram_rdata;
                end
            end
            if (flush) foreach (q_orphan[i]) q_orphan[i] = 1;
            if (exe_valid && exe_req_sent && allow) q_orphan.push_back(flush);
            if (exe_valid && allow) begin
                m_pc = exe_pc; m_res = exe_result; m_op = exe_ld_op;
                m_req = exe_req_sent; m_we = exe_gr_we; m_dest = exe_dest;
                m_exc = exe_exc; m_side = exe_side; m_have = 0;
            end
            if (flush) m_valid = 0;
            else if (allow) m_valid = exe_valid;
        end
    endtask

    task automatic compare();
        chk("allowin",  mem_allowin, m_allow());
        chk("wb_valid", wb_valid,    m_valid && m_ready() && !flush);
        chk("wb_pc",    wb_pc,       m_pc);
        chk("wb_result",wb_result,   m_final());
        chk("wb_dest",  wb_dest,     m_dest);
        chk("wb_gr_we", wb_gr_we,    m_we);
        chk("wb_exc",   wb_exc,      m_exc);
        chk("wb_side",  wb_side,     m_side);
        chk("mem_exc",  mem_exc,     m_valid && (m_exc != 0));
        chk("fwd_valid",fwd_valid,   m_valid && m_we);
        chk("fwd_dest", fwd_dest,    m_dest);
        chk("fwd_data", fwd_data,    m_final());
        chk("fwd_pend", fwd_pending, m_valid && (m_op != 0) && !m_have && (m_exc == 0));
        chk("req_block",req_block,   orphans() >= MAX_OUTST - 1);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        #2;
        compare();
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle();
        exe_valid = 0; exe_pc = 0; exe_result = 0; exe_ld_op = 0; exe_st = 0;
        exe_req_sent = 0; exe_gr_we = 0; exe_dest = 0; exe_exc = 0; exe_side = 0;
        data_sram_data_ok = 0; data_sram_rdata = 0; flush = 0; wb_allowin = 1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [2:0] op,
                         input logic st, input logic req, input logic we,
                         input logic [4:0] d, input logic [EXC_W-1:0] e);
        exe_valid = 1; exe_pc = pc; exe_result = res; exe_ld_op = op; exe_st = st;
        exe_req_sent = req; exe_gr_we = we; exe_dest = d; exe_exc = e;
        exe_side = {pc, res, 16'hA55A};
    endtask

    task automatic dok(input logic [31:0] d);
        data_sram_data_ok = 1;
        data_sram_rdata   = d;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t vecs[7];

    initial begin
        vecs[0] = '{3'd1, 32'h1000_0003, 32'h80FF_0000, 32'hFFFF_FF80};
        vecs[1] = '{3'd5, 32'h1000_0002, 32'h80FF_0000, 32'h0000_80FF};
        vecs[2] = '{3'd2, 32'h1000_0000, 32'h1234_8001, 32'hFFFF_8001};
        vecs[3] = '{3'd4, 32'h1000_0001, 32'h0000_A500, 32'h0000_00A5};
        vecs[4] = '{3'd3, 32'h1000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[5] = '{3'd1, 32'h1000_0000, 32'h0000_007F, 32'h0000_007F};
        vecs[6] = '{3'd2, 32'h1000_0002, 32'h7FFF_0000, 32'h0000_7FFF};

        idle();
        resetn = 0;
        nxt();
        nxt(); #3;
        chk("rst_allowin", mem_allowin, 1);
        chk("rst_wbv",     wb_valid,    0);
        chk("rst_block",   req_block,   0);
        chk("rst_fwdv",    fwd_valid,   0);
        chk("rst_result",  wb_result,   0);
        chk("rst_pend",    fwd_pending, 0);
        nxt(); resetn = 1;

        // ALU pass-through
        nxt(); idle(); issue(32'h1C00_0000, 32'h1234, 3'd0, 0, 0, 1, 5'd5, '0);
        nxt(); idle(); #3;
        chk("alu_wbv", wb_valid, 1);
        chk("alu_res", wb_result, 32'h1234);
        chk("alu_pend", fwd_pending, 0);
        nxt(); idle(); #3;
        chk("alu_done", wb_valid, 0);

        // ld.b with a late response
        nxt(); idle(); issue(32'h1C00_0004, 32'h1000_0003, 3'd1, 0, 1, 1, 5'd6, '0);
        nxt(); idle(); #3;
        chk("ldb_pend1", fwd_pending, 1);
        chk("ldb_hold", mem_allowin, 0);
        chk("ldb_wbv0", wb_valid, 0);
        nxt(); idle(); #3;
        chk("ldb_pend2", fwd_pending, 1);
        nxt(); idle(); dok(32'h80FF_0000); #3;
        chk("ldb_pend3", fwd_pending, 1);
        nxt(); idle(); #3;
        chk("ldb_wbv", wb_valid, 1);
        chk("ldb_res", wb_result, 32'hFFFF_FF80);
        chk("ldb_pend0", fwd_pending, 0);

        // Load extraction table, response on the earliest cycle
        for (int i = 0; i < 7; i++) begin
            nxt(); idle(); issue(32'h1C00_0100 + 4 * i, vecs[i].addr, vecs[i].op, 0, 1, 1, 5'd8, '0);
            nxt(); idle(); dok(vecs[i].rdata); #3;
            chk("tbl_pend", fwd_pending, 1);
            nxt(); idle(); #3;
            chk("tbl_wbv", wb_valid, 1);
            chk("tbl_res", wb_result, vecs[i].exp);
        end

        // Response while WB stalls
        nxt(); idle(); issue(32'h1C00_0200, 32'h0000_0020, 3'd3, 0, 1, 1, 5'd7, '0);
        nxt(); idle(); wb_allowin = 0; dok(32'hCAFE_F00D);
        repeat (3) begin
            nxt(); idle(); wb_allowin = 0; #3;
            chk("stall_wbv", wb_valid, 1);
            chk("stall_res", wb_result, 32'hCAFE_F00D);
            chk("stall_allowin", mem_allowin, 0);
        end
        nxt(); idle(); #3;
        chk("stall_accept", wb_valid, 1);
        nxt(); idle(); #3;
        chk("stall_nodup", wb_valid, 0);

        // Load carrying an exception: address forwarded, no wait
        nxt(); idle(); issue(32'h1C00_0300, 32'hBADC_0DE0, 3'd3, 0, 0, 1, 5'd9, 16'h0040);
        nxt(); idle(); #3;
        chk("exc_wbv", wb_valid, 1);
        chk("exc_res", wb_result, 32'hBADC_0DE0);
        chk("exc_mem", mem_exc, 1);
        chk("exc_pend", fwd_pending, 0);

        // Store waits for its response but never reports pending data
        nxt(); idle(); issue(32'h1C00_0400, 32'h0000_2000, 3'd0, 1, 1, 0, 5'd0, '0);
        nxt(); idle(); #3;
        chk("st_hold", mem_allowin, 0);
        chk("st_pend", fwd_pending, 0);
        nxt(); idle(); dok(32'hFFFF_FFFF);
        nxt(); idle(); #3;
        chk("st_wbv", wb_valid, 1);
        chk("st_res", wb_result, 32'h0000_2000);

        // Two orphans: flush on a waiting load, then flush with an EXE issue
        nxt(); idle(); issue(32'h1C00_0500, 32'h30, 3'd3, 0, 1, 1, 5'd10, '0);
        nxt(); idle(); flush = 1; #3;
        chk("fl_wbv", wb_valid, 0);
        nxt(); idle(); flush = 1; issue(32'h1C00_0504, 32'h34, 3'd3, 0, 1, 1, 5'd10, '0); #3;
        chk("fl_allowin", mem_allowin, 1);
        chk("fl_blk0", req_block, 0);
        nxt(); idle(); dok(32'h1111_1111); #3;
        chk("fl_blk1", req_block, 1);
        nxt(); idle(); dok(32'h2222_2222); issue(32'h1C00_0508, 32'h38, 3'd3, 0, 1, 1, 5'd11, '0); #3;
        chk("fl_blk_release", req_block, 0);
        nxt(); idle(); dok(32'h3333_3333); #3;
        chk("fl_pend", fwd_pending, 1);
        nxt(); idle(); #3;
        chk("fl_wbv3", wb_valid, 1);
        chk("fl_res3", wb_result, 32'h3333_3333);

        // Flush coincident with a dropped response while one orphan exists
        nxt(); idle(); issue(32'h1C00_0600, 32'h50, 3'd3, 0, 1, 1, 5'd12, '0);
        nxt(); idle(); flush = 1;
        nxt(); idle(); issue(32'h1C00_0604, 32'h54, 3'd3, 0, 1, 1, 5'd12, '0);
        nxt(); idle(); flush = 1; dok(32'h4444_4444); #3;
        chk("fd_wbv", wb_valid, 0);
        nxt(); idle(); dok(32'h5555_5555); #3;
        chk("fd_blk", req_block, 0);
        chk("fd_empty", mem_allowin, 1);
        nxt(); idle(); issue(32'h1C00_0608, 32'h58, 3'd3, 0, 1, 1, 5'd12, '0);
        nxt(); idle(); dok(32'h6666_6666);
        nxt(); idle(); #3;
        chk("fd_res", wb_result, 32'h6666_6666);
        chk("fd_wbv2", wb_valid, 1);

        // Flush coincident with the stage's own response: consumed, no orphan
        nxt(); idle(); issue(32'h1C00_0700, 32'h60, 3'd3, 0, 1, 1, 5'd13, '0);
        nxt(); idle(); flush = 1; dok(32'h7777_7777);
        nxt(); idle(); flush = 1;                      // empty stage, no issue
        nxt(); idle(); issue(32'h1C00_0704, 32'h64, 3'd3, 0, 1, 1, 5'd13, '0);
        nxt(); idle(); dok(32'h8888_8888);
        nxt(); idle(); #3;
        chk("fc_res", wb_result, 32'h8888_8888);
        chk("fc_wbv", wb_valid, 1);

        // Reset while an orphan is outstanding
        nxt(); idle(); issue(32'h1C00_0800, 32'h70, 3'd3, 0, 1, 1, 5'd14, '0);
        nxt(); idle(); flush = 1;
        nxt(); idle(); issue(32'h1C00_0804, 32'h74, 3'd3, 0, 1, 1, 5'd14, '0);
        nxt(); idle(); resetn = 0;
        nxt(); idle(); resetn = 1; #3;
        chk("rr_blk", req_block, 0);
        chk("rr_wbv", wb_valid, 0);
        chk("rr_allowin", mem_allowin, 1);
        nxt(); idle(); issue(32'h1C00_0808, 32'h78, 3'd3, 0, 1, 1, 5'd14, '0);
        nxt(); idle(); dok(32'h9999_9999);
        nxt(); idle(); #3;
        chk("rr_res", wb_result, 32'h9999_9999);

        nxt(); idle();
        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL timeout: got no end of stimulus, expected finish before 100000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
